// File: rtl/step_profile_gen.sv
// rtl/step_profile_gen.sv - table-driven stepper STEP pulse generator
//
// Plays a profile of up to DEPTH segments, each giving a half-period in
// clocks and a step count, on the single STEP output `pulse`.
//
// Optional feature macro: STEP_PROFILE_LOOP_EN (adds `loop`, which restarts
// the profile at entry 0 seamlessly instead of finishing).
//
// Ports:
//   CLK, RESET       clock (rising edge), synchronous active-low reset
//   start            level: high runs the profile, low aborts / re-arms
//   wr_en/wr_addr    profile table write strobe and entry address
//   wr_half          half-period in clocks (0 is treated as 1)
//   wr_steps         step count (0 marks end of profile)
//   wr_last          entry is the final segment
//   loop             (STEP_PROFILE_LOOP_EN only) repeat profile at its end
//   pulse            STEP output
//   busy             high while loading or running
//   done             one-cycle strobe on profile completion
//   seg_idx          index of the segment being played
//   steps_left       steps remaining in the current segment
module step_profile_gen #(
    parameter int CNT_W = 28,
    parameter int STP_W = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CNT_W-1:0] wr_half,
    input  logic [STP_W-1:0] wr_steps,
    input  logic             wr_last,
`ifdef STEP_PROFILE_LOOP_EN
    input  logic             loop,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    seg_idx,
    output logic [STP_W-1:0] steps_left
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Profile table; contents deliberately survive reset.
    logic [CNT_W-1:0] tab_half  [DEPTH];
    logic [STP_W-1:0] tab_steps [DEPTH];
    logic             tab_last  [DEPTH];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [STP_W-1:0] steps_q, steps_d;
    logic [AW-1:0]    seg_q, seg_d;
    logic             last_q, last_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;

    logic             loop_en;
    logic             ld;
    logic [AW-1:0]    ld_idx;
    logic [AW-1:0]    next_idx;
    logic             prof_end;

`ifdef STEP_PROFILE_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tab_half[wr_addr]  <= wr_half;
            tab_steps[wr_addr] <= wr_steps;
            tab_last[wr_addr]  <= wr_last;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            steps_q <= '0;
            seg_q   <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            steps_q <= steps_d;
            seg_q   <= seg_d;
            last_q  <= last_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    assign next_idx = seg_q + AW'(1);
    // Profile ends after this segment if it is flagged last, is the final
    // table slot, or the following entry is an end marker.
    assign prof_end = last_q || (seg_q == LAST_IDX) || (tab_steps[next_idx] == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        steps_d = steps_q;
        seg_d   = seg_q;
        last_d  = last_q;
        pulse_d = pulse_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        ld_idx  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ld      = 1'b1;
                end
            end
            S_LOAD: begin
                if (!start) begin
                    state_d = S_IDLE;
                    pulse_d = 1'b0;
                end else if (steps_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!start) begin
                    state_d = S_IDLE;
                    pulse_d = 1'b0;
                end else if (cnt_q == half_q) begin
                    cnt_d   = ONE;
                    pulse_d = ~pulse_q;
                    // A step completes on the falling toggle.
                    if (pulse_q) begin
                        if (steps_q == STP_W'(1)) begin
                            if (!prof_end) begin
                                ld     = 1'b1;
                                ld_idx = next_idx;
                            end else if (loop_en && (tab_steps[0] != '0)) begin
                                ld = 1'b1;
                            end else begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            steps_d = steps_q - STP_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DONE: begin
                pulse_d = 1'b0;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Latching happens in the same cycle as the advance so segments
        // abut with no gap cycle.
        if (ld) begin
            half_d  = (tab_half[ld_idx] == '0) ? ONE : tab_half[ld_idx];
            steps_d = tab_steps[ld_idx];
            last_d  = tab_last[ld_idx];
            seg_d   = ld_idx;
            cnt_d   = ONE;
        end
    end

    assign pulse      = pulse_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done       = done_q;
    assign seg_idx    = seg_q;
    assign steps_left = steps_q;

endmodule
